pc_sequencer: RTL and testbench

//  Owns the program counter for the 5-stage pipeline and decides each cycle's next-PC source:
//  PC+4, EX-stage taken branch, ID-stage jump, or ID-stage jr.

---
 rtl/pipeline_pkg.sv | 31 +++
 rtl/pc_sequencer_if.sv | 41 ++++
 rtl/pc_redirect_hold.sv | 44 ++++
 rtl/pc_sequencer.sv | 144 ++++++++++++++
 tb/tb_pc_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the fetch-stage PC sequencer: FSM states, redirect kinds, PC-mux selects.
// Consumed by pc_sequencer and pc_redirect_hold (PC_SEQ_EXC_EN adds no types here).
package pipeline_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        KIND_BR = 2'd0,
        KIND_JR = 2'd1,
        KIND_J  = 2'd2
    } redirect_kind_t;

    localparam logic [2:0] SEL_PC4 = 3'b000;
    localparam logic [2:0] SEL_BR  = 3'b100;
    localparam logic [2:0] SEL_J   = 3'b010;
    localparam logic [2:0] SEL_JR  = 3'b001;

    function automatic logic [2:0] kind_to_sel(input redirect_kind_t kind);
        case (kind)
            KIND_BR: return SEL_BR;
            KIND_JR: return SEL_JR;
            KIND_J:  return SEL_J;
            default: return SEL_PC4;
        endcase
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Pipeline <-> PC sequencer signal bundle; slave is the sequencer, master is the pipeline.
// With PC_SEQ_EXC_EN defined the bundle also carries exc_req and epc.
interface pc_sequencer_if #(
    parameter int PC_W = 32
);
    logic            stall;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            jump_id;
    logic [PC_W-1:0] jump_target;
    logic            jr_id;
    logic [PC_W-1:0] rs_value;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc4;
    logic [2:0]      sel;
    logic            fetch_valid;
    logic            flush_if_id;
    logic            flush_id_ex;
    logic            redirect_pend;
`ifdef PC_SEQ_EXC_EN
    logic            exc_req;
    logic [PC_W-1:0] epc;
`endif

    modport master (
`ifdef PC_SEQ_EXC_EN
        output exc_req, input epc,
`endif
        output stall, br_taken, br_target, jump_id, jump_target, jr_id, rs_value,
        input  pc, pc4, sel, fetch_valid, flush_if_id, flush_id_ex, redirect_pend
    );

    modport slave (
`ifdef PC_SEQ_EXC_EN
        input exc_req, output epc,
`endif
        input  stall, br_taken, br_target, jump_id, jump_target, jr_id, rs_value,
        output pc, pc4, sel, fetch_valid, flush_if_id, flush_id_ex, redirect_pend
    );

endinterface

// File: rtl/pc_redirect_hold.sv
// Single-entry pending-redirect register used while the PC is stalled.
// A branch displaces a held jump/jr; a jump/jr never displaces a held branch. Unaffected by PC_SEQ_EXC_EN.
module pc_redirect_hold
    import pipeline_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            cap,
    input  redirect_kind_t  cap_kind,
    input  logic [PC_W-1:0] cap_target,
    output logic            valid,
    output redirect_kind_t  kind,
    output logic [PC_W-1:0] target
);

    logic            valid_reg;
    redirect_kind_t  kind_reg;
    logic [PC_W-1:0] target_reg;
    logic            accept;

    assign accept = cap && (!valid_reg || (cap_kind == KIND_BR) || (kind_reg != KIND_BR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= 1'b0;
            kind_reg   <= KIND_BR;
            target_reg <= '0;
        end else if (clr) begin
            valid_reg  <= 1'b0;
        end else if (accept) begin
            valid_reg  <= 1'b1;
            kind_reg   <= cap_kind;
            target_reg <= cap_target;
        end
    end

    assign valid  = valid_reg;
    assign kind   = kind_reg;
    assign target = target_reg;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner for the 5-stage pipeline: next-PC arbitration, stall hold, redirect latching, flushes.
// Define PC_SEQ_EXC_EN to add the exc_req / epc exception path.
module pc_sequencer
    import pipeline_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0
`ifdef PC_SEQ_EXC_EN
    ,
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(32'h0000_0080)
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_sequencer_if.slave bus
);

    seq_state_t      state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [2:0]      sel_next;
    logic            flush_if_next, flush_ex_next;

    logic            req_valid;
    redirect_kind_t  req_kind;
    logic [PC_W-1:0] req_target;

    logic            hold_clr, hold_cap;
    logic            pend_valid;
    redirect_kind_t  pend_kind;
    logic [PC_W-1:0] pend_target;

    // Same-cycle arbitration: a taken branch squashes the wrong-path ID jump/jr.
    always_comb begin
        req_valid  = bus.br_taken | bus.jr_id | bus.jump_id;
        req_kind   = KIND_BR;
        req_target = bus.br_target;
        if (!bus.br_taken && bus.jr_id) begin
            req_kind   = KIND_JR;
            req_target = bus.rs_value;
        end else if (!bus.br_taken && bus.jump_id) begin
            req_kind   = KIND_J;
            req_target = bus.jump_target;
        end
    end

    pc_redirect_hold #(.PC_W(PC_W)) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (hold_clr),
        .cap        (hold_cap),
        .cap_kind   (req_kind),
        .cap_target (req_target),
        .valid      (pend_valid),
        .kind       (pend_kind),
        .target     (pend_target)
    );

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        sel_next      = SEL_PC4;
        hold_clr      = 1'b0;
        hold_cap      = 1'b0;
        flush_if_next = req_valid;
        flush_ex_next = bus.br_taken;
        case (state_reg)
            S_BOOT: state_next = S_RUN;
            S_RUN: begin
                if (bus.stall) begin
                    if (req_valid) begin
                        hold_cap   = 1'b1;
                        state_next = S_PEND;
                    end
                end else if (req_valid) begin
                    pc_next  = req_target;
                    sel_next = kind_to_sel(req_kind);
                end else begin
                    pc_next = pc_reg + PC_W'(4);
                end
            end
            S_PEND: begin
                if (bus.stall) begin
                    hold_cap = req_valid;
                end else begin
                    // Release: a fresh branch beats the latched entry, which is then dropped.
                    hold_clr   = 1'b1;
                    state_next = S_RUN;
                    if (bus.br_taken) begin
                        pc_next  = bus.br_target;
                        sel_next = SEL_BR;
                    end else begin
                        pc_next  = pend_target;
                        sel_next = kind_to_sel(pend_kind);
                    end
                end
            end
            default: state_next = S_BOOT;
        endcase
`ifdef PC_SEQ_EXC_EN
        if (bus.exc_req) begin
            pc_next       = EXC_VECTOR;
            sel_next      = SEL_PC4;
            flush_if_next = 1'b1;
            flush_ex_next = 1'b1;
            hold_clr      = 1'b1;
            hold_cap      = 1'b0;
            state_next    = S_RUN;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_BOOT;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

`ifdef PC_SEQ_EXC_EN
    logic [PC_W-1:0] epc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc_reg <= '0;
        end else if (bus.exc_req) begin
            epc_reg <= pc_reg;
        end
    end

    assign bus.epc = epc_reg;
`endif

    assign bus.pc            = pc_reg;
    assign bus.pc4           = pc_reg + PC_W'(4);
    assign bus.sel           = sel_next;
    assign bus.fetch_valid   = (state_reg != S_BOOT);
    assign bus.flush_if_id   = flush_if_next;
    assign bus.flush_id_ex   = flush_ex_next;
    assign bus.redirect_pend = pend_valid;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic against a rule-level model.
// Builds with or without PC_SEQ_EXC_EN; the exception path is exercised only when it is defined.
module tb_pc_sequencer;

    localparam int          PC_W       = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;
    localparam int K_BR = 1;
    localparam int K_JR = 2;
    localparam int K_J  = 3;
`ifdef PC_SEQ_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [2:0]  sel;
        logic        fv;
        logic        f1;
        logic        f2;
        logic        pend;
        logic [31:0] epc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(PC_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    // Reference model state: what the PC is, whether boot is done, and the one held redirect.
    logic [31:0] m_pc;
    bit          m_booted;
    bit          m_pv;
    int          m_pk;
    logic [31:0] m_pt;
    logic [31:0] m_epc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [2:0] sel_of(input int k);
        case (k)
            K_BR:    return 3'b100;
            K_JR:    return 3'b001;
            K_J:     return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Apply one cycle of inputs, record what the DUT must show this cycle, advance the model.
    task automatic drive(input bit st, input bit br, input logic [31:0] bt,
                         input bit j, input logic [31:0] jt,
                         input bit jr, input logic [31:0] rs, input bit exc);
        exp_t e;
        bus.stall       = st;
        bus.br_taken    = br;
        bus.br_target   = bt;
        bus.jump_id     = j;
        bus.jump_target = jt;
        bus.jr_id       = jr;
        bus.rs_value    = rs;
`ifdef PC_SEQ_EXC_EN
        bus.exc_req     = exc;
`endif
        e.pc   = m_pc;
        e.pc4  = m_pc + 32'd4;
        e.fv   = m_booted;
        e.pend = m_pv;
        e.epc  = m_epc;
        e.f1   = br | j | jr;
        e.f2   = br;
        e.sel  = 3'b000;
        if (EXC_EN && exc) begin
            e.f1 = 1'b1;
            e.f2 = 1'b1;
            m_epc = m_pc;
            m_pc = EXC_VECTOR;
            m_pv = 1'b0;
            m_booted = 1'b1;
        end else if (!m_booted) begin
            m_booted = 1'b1;
        end else if (st) begin
            if (br) begin
                m_pv = 1'b1; m_pk = K_BR; m_pt = bt;
            end else if ((jr || j) && !(m_pv && m_pk == K_BR)) begin
                m_pv = 1'b1;
                m_pk = jr ? K_JR : K_J;
                m_pt = jr ? rs : jt;
            end
        end else begin
            if (br)        begin e.sel = 3'b100;       m_pc = bt;   end
            else if (m_pv) begin e.sel = sel_of(m_pk); m_pc = m_pt; end
            else if (jr)   begin e.sel = 3'b001;       m_pc = rs;   end
            else if (j)    begin e.sel = 3'b010;       m_pc = jt;   end
            else           m_pc = m_pc + 32'd4;
            m_pv = 1'b0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit st);
        drive(st, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", bus.pc, RESET_PC);
        check("async_rst_pend", 32'(bus.redirect_pend), 32'd0);
        check("async_rst_fv", 32'(bus.fetch_valid), 32'd0);
        m_pc = RESET_PC; m_booted = 1'b0; m_pv = 1'b0; m_pk = 0; m_pt = '0; m_epc = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: one expected entry per DUT cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: pc=%h sel=%b fv=%b flush=%b%b pend=%b", n_txn,
                         bus.pc, bus.sel, bus.fetch_valid, bus.flush_if_id, bus.flush_id_ex,
                         bus.redirect_pend);
                check("pc", bus.pc, e.pc);
                check("pc4", bus.pc4, e.pc4);
                check("sel", 32'(bus.sel), 32'(e.sel));
                check("fetch_valid", 32'(bus.fetch_valid), 32'(e.fv));
                check("flush_if_id", 32'(bus.flush_if_id), 32'(e.f1));
                check("flush_id_ex", 32'(bus.flush_id_ex), 32'(e.f2));
                check("redirect_pend", 32'(bus.redirect_pend), 32'(e.pend));
`ifdef PC_SEQ_EXC_EN
                check("epc", bus.epc, e.epc);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          st, br, j, jr, exc;
        logic [31:0] bt, jt, rs;
        bus.stall = 0; bus.br_taken = 0; bus.br_target = 0; bus.jump_id = 0;
        bus.jump_target = 0; bus.jr_id = 0; bus.rs_value = 0;
`ifdef PC_SEQ_EXC_EN
        bus.exc_req = 0;
`endif
        // Reset release and free-running fetch.
        do_reset();
        repeat (4) idle(1'b0);
        // Branch beats a same-cycle jump.
        drive(0, 1, 32'h40, 1, 32'h80, 0, 0, 0);
        idle(0);
        // jr latched under a 3-cycle stall.
        drive(1, 0, 0, 0, 0, 1, 32'h200, 0);
        idle(1); idle(1);
        idle(0); idle(0);
        // Pending jump displaced by a branch; later jr cannot displace the branch.
        drive(1, 0, 0, 1, 32'h100, 0, 0, 0);
        drive(1, 1, 32'h300, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 32'h500, 0);
        idle(0); idle(0);
        // Newer jr replaces a pending jump.
        drive(1, 0, 0, 1, 32'h600, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 32'h700, 0);
        idle(0); idle(0);
        // Branch arriving in the release cycle wins over the pending jr.
        drive(1, 0, 0, 0, 0, 1, 32'h800, 0);
        drive(0, 1, 32'h900, 0, 0, 0, 0, 0);
        idle(0);
        // Reset while a redirect is pending.
        drive(1, 0, 0, 0, 0, 1, 32'h1000, 0);
        idle(1);
        do_reset();
        idle(0); idle(0);
        // Wrap at the top of the address space, then an unaligned target.
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        idle(0); idle(0);
        drive(0, 0, 0, 1, 32'h13, 0, 0, 0);
        idle(0);
        // Exception beats stall and branch.
        drive(0, 0, 0, 1, 32'h24, 0, 0, 0);
        drive(1, 1, 32'h44, 0, 0, 0, 0, EXC_EN);
        idle(0); idle(0);
        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            st  = ($urandom_range(0, 9) < 4);
            br  = ($urandom_range(0, 9) < 2);
            j   = ($urandom_range(0, 9) < 2);
            jr  = ($urandom_range(0, 9) < 2);
            exc = EXC_EN && ($urandom_range(0, 24) == 0);
            bt  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom);
            jt  = 32'($urandom);
            rs  = 32'($urandom);
            drive(st, br, bt, j, jt, jr, rs, exc);
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
        end
        idle(0);
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
